// File: rtl/mem_access_if.sv
// mem_access_if: data-memory request/acknowledge bus.
// Signals:
//   dmem_req   - request, held until acknowledged
//   dmem_we    - 1 = store, 0 = load
//   dmem_addr  - bus address
//   dmem_wdata - store data
//   dmem_ack   - acknowledge, completes the transfer when seen with dmem_req
//   dmem_rdata - load data, valid on the acknowledging edge
// Modports: master (memory-access stage), slave (memory).
interface mem_access_if;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic        dmem_ack;
    logic [31:0] dmem_rdata;
    modport master (output dmem_req, dmem_we, dmem_addr, dmem_wdata, input dmem_ack, dmem_rdata);
    modport slave  (input dmem_req, dmem_we, dmem_addr, dmem_wdata, output dmem_ack, dmem_rdata);
endinterface

// File: rtl/mem_access.sv
// mem_access: memory-access stage, one data-memory transfer per MEM phase.
// Ports:
//   clk, rst (async, active-low)
//   state, mem_read_in, mem_write_in, reg_write_in, write_reg_in,
//   mem_addr, mem_write_data, alu_result  - exec results, captured in IDLE when state==3
//   bus (mem_access_if.master)            - data-memory request/ack bus
//   reg_write_out, write_reg_out, wb_data - write-back result, updated on entry to DONE
//   done, busy, err                       - sequencer status
// Optional feature: define MEM_ALIGN_CHECK_EN to fail misaligned loads/stores without a bus request.
module mem_access #(
    parameter int unsigned WAIT_LIMIT = 255
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [2:0]          state,
    input  logic                mem_read_in,
    input  logic                mem_write_in,
    input  logic                reg_write_in,
    input  logic [4:0]          write_reg_in,
    input  logic [31:0]         mem_addr,
    input  logic [31:0]         mem_write_data,
    input  logic [31:0]         alu_result,
    mem_access_if.master        bus,
    output logic                reg_write_out,
    output logic [4:0]          write_reg_out,
    output logic [31:0]         wb_data,
    output logic                done,
    output logic                busy,
    output logic                err
);
    typedef enum logic [1:0] {IDLE, REQ, DONE} st_e;
    st_e         st_q, st_d;
    logic        we_q, we_d, rw_q, rw_d, rwo_q, rwo_d, err_q, err_d;
    logic [4:0]  wr_q, wr_d, wro_q, wro_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [31:0] addr_q, addr_d, wdata_q, wdata_d, alu_q, alu_d, wb_q, wb_d;
    logic        misalign;
`ifdef MEM_ALIGN_CHECK_EN
    assign misalign = (mem_read_in | mem_write_in) & (mem_addr[1:0] != 2'b00);
`else
    assign misalign = 1'b0;
`endif
    always_comb begin
        st_d    = st_q;
        we_d    = we_q;
        rw_d    = rw_q;
        wr_d    = wr_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        alu_d   = alu_q;
        cnt_d   = cnt_q;
        rwo_d   = rwo_q;
        wro_d   = wro_q;
        wb_d    = wb_q;
        err_d   = err_q;
        case (st_q)
            IDLE: if (state == 3'd3) begin
                we_d    = mem_write_in;
                rw_d    = reg_write_in;
                wr_d    = write_reg_in;
                addr_d  = mem_addr;
                wdata_d = mem_write_data;
                alu_d   = alu_result;
                cnt_d   = '0;
                if ((mem_read_in | mem_write_in) & ~misalign) begin
                    st_d = REQ;
                end else begin
                    st_d  = DONE;
                    rwo_d = reg_write_in & (write_reg_in != 5'd0) & ~misalign;
                    wro_d = write_reg_in;
                    wb_d  = alu_result;
                    err_d = misalign;
                end
            end
            REQ: if (bus.dmem_ack) begin
                st_d  = DONE;
                rwo_d = rw_q & (wr_q != 5'd0);
                wro_d = wr_q;
                wb_d  = we_q ? alu_q : bus.dmem_rdata;
                err_d = 1'b0;
            end else if (cnt_q == 8'(WAIT_LIMIT - 1)) begin
                // ack on the final edge still wins over the timeout
                st_d  = DONE;
                rwo_d = 1'b0;
                wro_d = wr_q;
                wb_d  = alu_q;
                err_d = 1'b1;
            end else begin
                cnt_d = cnt_q + 8'd1;
            end
            DONE: st_d = IDLE;
            default: st_d = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            st_q    <= IDLE;
            we_q    <= 1'b0;
            rw_q    <= 1'b0;
            wr_q    <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            alu_q   <= '0;
            cnt_q   <= '0;
            rwo_q   <= 1'b0;
            wro_q   <= '0;
            wb_q    <= '0;
            err_q   <= 1'b0;
        end else begin
            st_q    <= st_d;
            we_q    <= we_d;
            rw_q    <= rw_d;
            wr_q    <= wr_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            alu_q   <= alu_d;
            cnt_q   <= cnt_d;
            rwo_q   <= rwo_d;
            wro_q   <= wro_d;
            wb_q    <= wb_d;
            err_q   <= err_d;
        end
    end
    assign bus.dmem_req   = (st_q == REQ);
    assign bus.dmem_we    = (st_q == REQ) & we_q;
    assign bus.dmem_addr  = (st_q == REQ) ? addr_q : '0;
    assign bus.dmem_wdata = (st_q == REQ) ? wdata_q : '0;
    assign reg_write_out  = rwo_q;
    assign write_reg_out  = wro_q;
    assign wb_data        = wb_q;
    assign done           = (st_q == DONE);
    assign busy           = (st_q != IDLE);
    assign err            = (st_q == DONE) & err_q;
endmodule

// File: tb/tb_mem_access.sv
// tb_mem_access: directed and randomized checks of mem_access against a transaction-level model.
module tb_mem_access;
    localparam int W = 4;
    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  state;
    logic        mem_read_in, mem_write_in, reg_write_in;
    logic [4:0]  write_reg_in;
    logic [31:0] mem_addr, mem_write_data, alu_result;
    logic        reg_write_out, done, busy, err;
    logic [4:0]  write_reg_out;
    logic [31:0] wb_data;
    int          compared = 0;
    int          mismatched = 0;
    mem_access_if bus();
    mem_access #(.WAIT_LIMIT(W)) dut (
        .clk(clk), .rst(rst), .state(state),
        .mem_read_in(mem_read_in), .mem_write_in(mem_write_in),
        .reg_write_in(reg_write_in), .write_reg_in(write_reg_in),
        .mem_addr(mem_addr), .mem_write_data(mem_write_data), .alu_result(alu_result),
        .bus(bus),
        .reg_write_out(reg_write_out), .write_reg_out(write_reg_out), .wb_data(wb_data),
        .done(done), .busy(busy), .err(err)
    );
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // k = edge index (after capture) at which ack is returned; 0 or >W means never
    task automatic run_txn(input logic rd, input logic wr, input logic rw, input logic [4:0] wreg,
                           input logic [31:0] addr, input logic [31:0] wdata, input logic [31:0] alu,
                           input int k, input logic [31:0] rdata);
        logic        mis, mem, acked, exp_err, exp_rwo, got;
        logic [31:0] exp_wb;
        int          exp_req, exp_lat, nreq;
        mem = rd | wr;
        mis = 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
        mis = mem && (addr[1:0] != 2'b00);
`endif
        acked   = (k >= 1) && (k <= W);
        exp_req = (!mem || mis) ? 0 : (acked ? k : W);
        exp_lat = exp_req + 1;
        exp_err = mis || (mem && !acked);
        exp_rwo = rw && (wreg != 5'd0) && !exp_err;
        exp_wb  = (rd && !wr) ? rdata : alu;
        state = 3'd3;
        mem_read_in = rd; mem_write_in = wr; reg_write_in = rw; write_reg_in = wreg;
        mem_addr = addr; mem_write_data = wdata; alu_result = alu;
        @(posedge clk);
        #1;
        // exec inputs change freely after capture and must be ignored
        state = 3'($urandom_range(0, 7));
        mem_read_in = 1'($urandom); mem_write_in = 1'($urandom); reg_write_in = 1'($urandom);
        write_reg_in = 5'($urandom); mem_addr = $urandom; mem_write_data = $urandom; alu_result = $urandom;
        nreq = 0;
        got = 1'b0;
        for (int n = 1; n <= W + 4 && !got; n++) begin
            @(negedge clk);
            bus.dmem_ack = 1'b0;
            if (n == 1) state = 3'd0;
            if (bus.dmem_req) begin
                nreq++;
                chk("dmem_addr", bus.dmem_addr, addr);
                chk("dmem_we", {31'b0, bus.dmem_we}, {31'b0, wr});
                if (wr) chk("dmem_wdata", bus.dmem_wdata, wdata);
                bus.dmem_ack = (n == k);
                bus.dmem_rdata = (n == k) ? rdata : $urandom;
            end
            if (done) begin
                got = 1'b1;
                chk("latency", n, exp_lat);
                chk("req_cycles", nreq, exp_req);
                chk("err", {31'b0, err}, {31'b0, exp_err});
                chk("reg_write_out", {31'b0, reg_write_out}, {31'b0, exp_rwo});
                chk("write_reg_out", {27'b0, write_reg_out}, {27'b0, wreg});
                chk("busy_in_done", {31'b0, busy}, 32'd1);
                if (!exp_err) chk("wb_data", wb_data, exp_wb);
            end
        end
        chk("done_seen", {31'b0, got}, 32'd1);
        @(negedge clk);
        bus.dmem_ack = 1'b0;
        chk("done_pulse", {31'b0, done}, 32'd0);
        chk("busy_idle", {31'b0, busy}, 32'd0);
        if (!exp_err) chk("wb_hold", wb_data, exp_wb);
    endtask

    initial begin
        logic        r_rd, r_wr, r_rw;
        logic [4:0]  r_wreg;
        logic [31:0] r_addr;
        int          r_k;
        rst = 1'b0;
        state = 3'd0;
        mem_read_in = 1'b0; mem_write_in = 1'b0; reg_write_in = 1'b0; write_reg_in = '0;
        mem_addr = '0; mem_write_data = '0; alu_result = '0;
        bus.dmem_ack = 1'b0; bus.dmem_rdata = '0;
        repeat (2) @(negedge clk);
        chk("rst_req", {31'b0, bus.dmem_req}, 32'd0);
        chk("rst_done", {31'b0, done}, 32'd0);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_err", {31'b0, err}, 32'd0);
        chk("rst_rwo", {31'b0, reg_write_out}, 32'd0);
        chk("rst_wb", wb_data, 32'd0);
        rst = 1'b1;
        @(negedge clk);
        // add x1 = 13
        run_txn(1'b0, 1'b0, 1'b1, 5'd1, 32'd0, 32'd0, 32'd13, 0, 32'd0);
        // lw x2, ack at E0+3
        run_txn(1'b1, 1'b0, 1'b1, 5'd2, 32'd36, 32'd0, 32'd7, 3, 32'hDEADBEEF);
        // sw, ack at E0+1
        run_txn(1'b0, 1'b1, 1'b0, 5'd5, 32'd148, 32'd11, 32'd99, 1, 32'h12345678);
        // load timeout
        run_txn(1'b1, 1'b0, 1'b1, 5'd3, 32'd40, 32'd0, 32'd1, 0, 32'd0);
        // add writing x0
        run_txn(1'b0, 1'b0, 1'b1, 5'd0, 32'd0, 32'd0, 32'd77, 0, 32'd0);
        // misaligned lw
        run_txn(1'b1, 1'b0, 1'b1, 5'd4, 32'd38, 32'd0, 32'd2, 2, 32'hCAFEF00D);
        // ack on the final permitted edge
        run_txn(1'b1, 1'b1, 1'b1, 5'd9, 32'd64, 32'hA5A5A5A5, 32'd55, W, 32'h0BADF00D);
        // reset while dmem_req is high
        state = 3'd3; mem_read_in = 1'b1; mem_write_in = 1'b0; reg_write_in = 1'b1;
        write_reg_in = 5'd6; mem_addr = 32'd80; alu_result = 32'd3;
        @(posedge clk);
        #1 state = 3'd0;
        @(negedge clk);
        chk("pre_rst_req", {31'b0, bus.dmem_req}, 32'd1);
        #2 rst = 1'b0;
        #1;
        chk("async_rst_req", {31'b0, bus.dmem_req}, 32'd0);
        chk("async_rst_busy", {31'b0, busy}, 32'd0);
        chk("async_rst_done", {31'b0, done}, 32'd0);
        chk("async_rst_wb", wb_data, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        bus.dmem_ack = 1'b1;
        bus.dmem_rdata = 32'h11111111;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("post_rst_busy", {31'b0, busy}, 32'd0);
            chk("post_rst_done", {31'b0, done}, 32'd0);
            chk("post_rst_rwo", {31'b0, reg_write_out}, 32'd0);
        end
        bus.dmem_ack = 1'b0;
        // randomized transactions
        for (int t = 0; t < 40; t++) begin
            r_rd = 1'($urandom);
            r_wr = ($urandom_range(0, 3) == 0);
            r_rw = 1'($urandom);
            r_wreg = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom);
            r_addr = $urandom;
            if ($urandom_range(0, 4) != 0) r_addr[1:0] = 2'b00;
            r_k = $urandom_range(0, W);
            run_txn(r_rd, r_wr, r_rw, r_wreg, r_addr, $urandom, $urandom, r_k, $urandom);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/mem_access.md
# mem_access

Memory-access stage of the multi-cycle core. Consumes the exec stage's results (memory control, effective address, store data, ALU result, destination register) when the core phase is MEM and performs at most one data-memory transfer over a request/acknowledge bus. Produces the write-back value and destination for the WB phase, and signals completion to the core sequencer.

## Interface
Parameters:
- WAIT_LIMIT, 255: maximum cycles `dmem_req` is held without `dmem_ack` before the transfer is abandoned (1..255).

Ports:
- clk  in  1  core clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-low reset (0 = reset).
- state  in  3  core phase; value 3 = MEM phase.
- mem_read_in  in  1  load request from exec.
- mem_write_in  in  1  store request from exec.
- reg_write_in  in  1  instruction writes a register.
- write_reg_in  in  5  destination register index.
- mem_addr  in  32  effective address from exec.
- mem_write_data  in  32  store data from exec.
- alu_result  in  32  exec's register write value (non-load instructions).
- dmem_req  out  1  bus request; held until acknowledged.
- dmem_we  out  1  1 = store, 0 = load.
- dmem_addr  out  32  bus address.
- dmem_wdata  out  32  bus store data.
- dmem_ack  in  1  bus acknowledge; completes the transfer when sampled high with `dmem_req` high.
- dmem_rdata  in  32  load data; valid on the acknowledging edge.
- reg_write_out  out  1  WB register write enable.
- write_reg_out  out  5  WB destination index.
- wb_data  out  32  WB value.
- done  out  1  one-cycle completion pulse.
- busy  out  1  high whenever the FSM is not in IDLE.
- err  out  1  high with `done` when the transfer failed.

## Operation
- FSM states: IDLE, REQ, DONE.
- IDLE: when `state`==3 at a rising edge, capture all exec inputs into internal registers.
  - If `mem_write_in`: go to REQ with `dmem_we`=1. Write wins if both read and write are high.
  - Else if `mem_read_in`: go to REQ with `dmem_we`=0.
  - Else: go to DONE; `wb_data`=`alu_result`.
- REQ:
  - `dmem_req`=1, and `dmem_addr`/`dmem_we`/`dmem_wdata` are driven from the captured registers and stay stable until the state is left.
  - On `dmem_ack`=1: go to DONE. A load sets `wb_data`=`dmem_rdata`; a store sets `wb_data`=`alu_result`.
  - A wait counter increments each REQ cycle. When it reaches WAIT_LIMIT without an ack: go to DONE with err=1 and `reg_write_out` forced 0.
- DONE: `done`=1 for exactly one cycle, then go to IDLE.
- `reg_write_out`/`write_reg_out`/`wb_data` update on entry to DONE and hold until the next entry to DONE.
- `reg_write_out` = captured `reg_write_in` AND (`write_reg_in`≠0) AND NOT err. Register x0 is never written.
- `state` and all exec inputs are ignored outside IDLE.
- `dmem_ack` is ignored whenever `dmem_req` is low.
- Reset: all outputs are 0, FSM goes to IDLE, and the counter clears. This applies immediately and asynchronously, including mid-REQ; an ack arriving after reset is ignored.

## Timing
- E0 = the capture edge.
- Non-memory instruction: DONE after E0; `done` high for the cycle following E0 (latency 1).
- Memory instruction: `dmem_req` rises after E0. An ack sampled at E0+k (k≥1) gives DONE after E0+k (latency k+1; minimum 2 with a zero-wait memory).
- Timeout: with no ack, `dmem_req` is high for exactly WAIT_LIMIT cycles, then DONE.
- IDLE follows one cycle after DONE. A new capture is possible on the edge that returns to IDLE+1.
- `busy` is registered with the FSM state: high from after E0 through the DONE cycle.

## Configuration
- MEM_ALIGN_CHECK_EN defined:
  - A load or store with `mem_addr[1:0]`≠0 issues no bus request.
  - It goes to DONE after E0 with err=1 and `reg_write_out`=0.
- MEM_ALIGN_CHECK_EN undefined:
  - No check; the address passes to `dmem_addr` unmodified.
  - err is asserted only by timeout.

## Test plan
- add: state=3, no mem, reg_write_in=1, write_reg_in=1, alu_result=13 -> done one cycle after E0, wb_data=13, reg_write_out=1, write_reg_out=1, dmem_req never high.
- lw x2: mem_read_in=1, mem_addr=36, ack at E0+3 with rdata=0xDEADBEEF -> dmem_req high 3 cycles with dmem_addr=36 and dmem_we=0 stable; then wb_data=0xDEADBEEF, write_reg_out=2, reg_write_out=1.
- sw: mem_write_in=1, mem_addr=148, mem_write_data=11, reg_write_in=0, ack at E0+1 -> one-cycle req with dmem_we=1 and dmem_wdata=11; done at E0+1; reg_write_out=0.
- Timeout (WAIT_LIMIT=4): load with no ack -> req high exactly 4 cycles, then done=1 with err=1 and reg_write_out=0. A write to x0 (write_reg_in=0) on an add -> reg_write_out=0.
- Reset mid-REQ: rst driven low while dmem_req=1 -> dmem_req, busy and done are 0 immediately. An ack after rst is released is ignored, and the FSM stays in IDLE.
- Misaligned lw, mem_addr=38 -> with MEM_ALIGN_CHECK_EN: no req, done+err after E0. Without MEM_ALIGN_CHECK_EN: req issued with dmem_addr=38.
